// File: rtl/act_relu6_seq.sv
// Streams len FP16 elements from a source buffer, applies ReLU6 and writes them to a
// destination buffer. Define ACT_RELU6_SATCNT_EN to add the sat_cnt clamp counter output.
module act_relu6_seq #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [ADDR_W:0]   len,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [15:0]       rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              busy,
`ifdef ACT_RELU6_SATCNT_EN
    output logic [ADDR_W:0]   sat_cnt,
`endif
    output logic              done
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   rd_cnt_q;
    logic [ADDR_W-1:0] wr_cnt_q;
    logic              pend_q;   // rd_data is valid this cycle
    logic [15:0]       act;
    logic              clamp;

    always_comb begin
        act   = rd_data;
        clamp = 1'b0;
        if (rd_data[15]) begin
            act = 16'h0000;
        end else if (rd_data[14:10] == 5'h1F && rd_data[9:0] != 10'h000) begin
            act = 16'h0000;
        end else if (rd_data[14:0] > 15'h4600) begin
            act   = 16'h4600;
            clamp = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            pend_q   <= 1'b0;
            rd_en    <= 1'b0;
            rd_addr  <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            pend_q <= rd_en;
            wr_en  <= pend_q;
            if (pend_q) begin
                wr_data  <= act;
                wr_addr  <= dst_q + wr_cnt_q;
                wr_cnt_q <= wr_cnt_q + ADDR_W'(1);
            end
            unique case (state_q)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        src_q    <= src_base;
                        dst_q    <= dst_base;
                        len_q    <= len;
                        wr_cnt_q <= '0;
                        if (len == '0) begin
                            rd_cnt_q <= '0;
                            done     <= 1'b1;
                            state_q  <= StDone;
                        end else begin
                            rd_en    <= 1'b1;
                            rd_addr  <= src_base;
                            rd_cnt_q <= (ADDR_W+1)'(1);
                            busy     <= 1'b1;
                            state_q  <= StRun;
                        end
                    end
                end
                StRun: begin
                    if (rd_cnt_q == len_q) begin
                        rd_en   <= 1'b0;
                        state_q <= StDrain;
                    end else begin
                        rd_addr  <= src_q + rd_cnt_q[ADDR_W-1:0];
                        rd_cnt_q <= rd_cnt_q + (ADDR_W+1)'(1);
                    end
                end
                StDrain: begin
                    // Last write is on the bus when nothing else is queued behind it.
                    if (wr_en && !pend_q) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef ACT_RELU6_SATCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt <= '0;
        end else if (state_q == StIdle && start) begin
            sat_cnt <= '0;
        end else if (pend_q && clamp) begin
            sat_cnt <= sat_cnt + (ADDR_W+1)'(1);
        end
    end
`endif

endmodule

// File: tb/tb_act_relu6_seq.sv
// Directed self-checking bench for act_relu6_seq with a 1-cycle-latency source memory model.
module tb_act_relu6_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  src_base;
    logic [7:0]  dst_base;
    logic [8:0]  len;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [15:0] rd_data;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        busy;
    logic        done;
`ifdef ACT_RELU6_SATCNT_EN
    logic [8:0]  sat_cnt;
`endif

    act_relu6_seq #(.ADDR_W(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .src_base(src_base),
        .dst_base(dst_base),
        .len     (len),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy),
`ifdef ACT_RELU6_SATCNT_EN
        .sat_cnt (sat_cnt),
`endif
        .done    (done)
    );

    int tests = 0;
    int fails = 0;

    logic [15:0] src_mem [256];
    logic [15:0] dst_mem [256];
    logic [7:0]  rd_log [$];
    logic [7:0]  wr_log [$];
    int          mcyc = 0;
    int          rd_c0 = 0;
    int          wr_c0 = 0;
    int          done_cnt = 0;
    int          viol = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) rd_data <= src_mem[rd_addr];
        if (wr_en) dst_mem[wr_addr] <= wr_data;
    end

    always @(posedge clk) begin
        #1;
        mcyc++;
        if (rst_n) begin
            if (rd_en) begin
                if (rd_log.size() == 0) rd_c0 = mcyc;
                rd_log.push_back(rd_addr);
            end
            if (wr_en) begin
                if (wr_log.size() == 0) wr_c0 = mcyc;
                wr_log.push_back(wr_addr);
            end
            if (done) done_cnt++;
            if ((rd_en || wr_en) && !busy) viol++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge; returns one cycle after done, back in IDLE.
    task automatic run_pass(input logic [7:0] s, input logic [7:0] d, input logic [8:0] l,
                            input bit dup, output int dcyc, output logic b1, output logic bd);
        rd_log.delete();
        wr_log.delete();
        done_cnt = 0;
        dcyc     = -1;
        bd       = 1'b1;
        b1       = 1'b0;
        src_base = s;
        dst_base = d;
        len      = l;
        start    = 1'b1;
        for (int k = 1; k <= 600; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                b1    = busy;
            end
            if (dup && k == 2) begin
                src_base = 8'h30;
                dst_base = 8'hC0;
                len      = 9'd2;
                start    = 1'b1;
            end
            if (dup && k == 3) start = 1'b0;
            if (done) begin
                dcyc = k;
                bd   = busy;
                break;
            end
        end
        @(negedge clk);
    endtask

    int   dcyc;
    logic b1;
    logic bd;
    int   bad;

    initial begin
        for (int i = 0; i < 256; i++) begin
            src_mem[i] = 16'h0000;
            dst_mem[i] = 16'hDEAD;
        end
        src_mem[8'h10] = 16'hBC00; src_mem[8'h11] = 16'h0000;
        src_mem[8'h12] = 16'h3C00; src_mem[8'h13] = 16'h4700;
        src_mem[8'hFE] = 16'h1111; src_mem[8'hFF] = 16'h2222; src_mem[8'h00] = 16'h3333;
        src_mem[8'h20] = 16'h7C00; src_mem[8'h21] = 16'h7E00; src_mem[8'h22] = 16'h8000;
        src_mem[8'h23] = 16'h0001; src_mem[8'h24] = 16'h4600;

        rst_n = 1'b0; start = 1'b0; src_base = '0; dst_base = '0; len = '0;
        #12;
        check("reset_strobes", {rd_en, wr_en, busy, done}, 4'b0000);
        check("reset_addrs", {rd_addr, wr_addr}, 16'h0000);
        check("reset_wdata", wr_data, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic pass, started on the first edge after reset release
        run_pass(8'h10, 8'h80, 9'd4, 1'b0, dcyc, b1, bd);
        check("basic_done_cycle", dcyc, 7);
        check("basic_busy_first", b1, 1'b1);
        check("basic_busy_at_done", bd, 1'b0);
        check("basic_data", {dst_mem[8'h80], dst_mem[8'h81]}, 32'h0000_0000);
        check("basic_data_hi", {dst_mem[8'h82], dst_mem[8'h83]}, 32'h3C00_4600);
        check("basic_rd_addrs", {rd_log[0], rd_log[1], rd_log[2], rd_log[3]}, 32'h10111213);
        check("basic_wr_count", wr_log.size(), 4);
        check("basic_latency", wr_c0 - rd_c0, 2);
        check("basic_done_pulses", done_cnt, 1);

        // Zero-length pass
        run_pass(8'h10, 8'h50, 9'd0, 1'b0, dcyc, b1, bd);
        check("len0_done_cycle", dcyc, 1);
        check("len0_busy", b1, 1'b0);
        check("len0_traffic", rd_log.size() + wr_log.size(), 0);
        check("len0_dst_untouched", dst_mem[8'h50], 16'hDEAD);

        // Address wrap
        run_pass(8'hFE, 8'hFF, 9'd3, 1'b0, dcyc, b1, bd);
        check("wrap_rd_addrs", {rd_log[0], rd_log[1], rd_log[2]}, 24'hFEFF00);
        check("wrap_wr_addrs", {wr_log[0], wr_log[1], wr_log[2]}, 24'hFF0001);
        check("wrap_data", {dst_mem[8'hFF], dst_mem[8'h00]}, 32'h1111_2222);
        check("wrap_done_cycle", dcyc, 6);

        // Special FP16 values
        run_pass(8'h20, 8'h40, 9'd5, 1'b0, dcyc, b1, bd);
        check("special_inf_nan", {dst_mem[8'h40], dst_mem[8'h41]}, 32'h4600_0000);
        check("special_negz_sub", {dst_mem[8'h42], dst_mem[8'h43]}, 32'h0000_0001);
        check("special_six", dst_mem[8'h44], 16'h4600);
`ifdef ACT_RELU6_SATCNT_EN
        check("special_sat_cnt", sat_cnt, 9'd1);
`endif

        // Reset in the middle of a len=8 pass
        src_base = 8'h10; dst_base = 8'h60; len = 9'd8; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_strobes", {rd_en, wr_en, busy, done}, 4'b0000);
        check("abort_addrs", {rd_addr, wr_addr}, 16'h0000);
        check("abort_wdata", wr_data, 16'h0000);
        rd_log.delete(); wr_log.delete(); done_cnt = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("abort_no_writes", wr_log.size(), 0);
        check("abort_no_done", done_cnt, 0);
        check("abort_dst_tail", dst_mem[8'h63], 16'hDEAD);
        run_pass(8'h12, 8'hA0, 9'd2, 1'b0, dcyc, b1, bd);
        check("post_abort_done_cycle", dcyc, 5);
        check("post_abort_data", {dst_mem[8'hA0], dst_mem[8'hA1]}, 32'h3C00_4600);

        // Second start while busy is ignored
        run_pass(8'h10, 8'h90, 9'd4, 1'b1, dcyc, b1, bd);
        check("dup_done_cycle", dcyc, 7);
        check("dup_done_pulses", done_cnt, 1);
        check("dup_wr_addrs", {wr_log[0], wr_log[1], wr_log[2], wr_log[3]}, 32'h90919293);
        check("dup_wr_count", wr_log.size(), 4);
        check("dup_data", {dst_mem[8'h92], dst_mem[8'h93]}, 32'h3C00_4600);
        check("dup_other_dst", dst_mem[8'hC0], 16'hDEAD);

        // Full 2^ADDR_W pass
        run_pass(8'h00, 8'h00, 9'd256, 1'b0, dcyc, b1, bd);
        check("full_done_cycle", dcyc, 259);
        check("full_rd_count", rd_log.size(), 256);
        check("full_wr_count", wr_log.size(), 256);
        bad = 0;
        for (int i = 0; i < 256 && i < rd_log.size() && i < wr_log.size(); i++) begin
            if (rd_log[i] != 8'(i) || wr_log[i] != 8'(i)) bad++;
        end
        check("full_addr_order", bad, 0);
        check("full_data", {dst_mem[8'h13], dst_mem[8'hFF]}, 32'h4600_2222);
`ifdef ACT_RELU6_SATCNT_EN
        check("full_sat_cnt", sat_cnt, 9'd2);
`endif
        check("no_strobe_when_idle", viol, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
